// File: rtl/reqgnt_lat_monitor.sv
// rtl/reqgnt_lat_monitor.sv - multi-channel req/gnt latency and ordering monitor
// Per channel, an in-order queue of outstanding request ages flags spurious, overflow, early and timeout events.
module reqgnt_lat_monitor #(
  parameter int NCH     = 4,
  parameter int DEPTH   = 8,
  parameter int MIN_LAT = 2,
  parameter int MAX_LAT = 8,
  parameter int CW      = $clog2(DEPTH + 1),
  parameter int AW      = $clog2(MAX_LAT + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    gnt,
  input  logic              clr_err,
  output logic [NCH*CW-1:0] outstanding,
  output logic [NCH-1:0]    err_spur,
  output logic [NCH-1:0]    err_ovf,
  output logic [NCH-1:0]    err_early,
  output logic [NCH-1:0]    err_tmo,
  output logic [NCH-1:0]    err_sticky
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] AGE_SAT  = AW'(MAX_LAT + 1);
  localparam logic [AW-1:0] AGE_MIN  = AW'(MIN_LAT);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic          valid_q   [NCH][DEPTH];
  logic          valid_d   [NCH][DEPTH];
  logic [AW-1:0] age_q     [NCH][DEPTH];
  logic [AW-1:0] age_d     [NCH][DEPTH];
  logic          tmo_rep_q [NCH][DEPTH];
  logic          tmo_rep_d [NCH][DEPTH];
  logic [PW-1:0] rd_q [NCH];
  logic [PW-1:0] rd_d [NCH];
  logic [PW-1:0] wr_q [NCH];
  logic [PW-1:0] wr_d [NCH];
  logic [CW-1:0] cnt_q [NCH];
  logic [CW-1:0] cnt_d [NCH];

  logic [NCH-1:0] err_spur_q, err_spur_d;
  logic [NCH-1:0] err_ovf_q, err_ovf_d;
  logic [NCH-1:0] err_early_q, err_early_d;
  logic [NCH-1:0] err_tmo_q, err_tmo_d;
  logic [NCH-1:0] err_sticky_q, err_sticky_d;
  logic [NCH-1:0] pop, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    valid_d     = valid_q;
    age_d       = age_q;
    tmo_rep_d   = tmo_rep_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    err_spur_d  = '0;
    err_ovf_d   = '0;
    err_early_d = '0;
    err_tmo_d   = '0;
    pop         = '0;
    push        = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (valid_q[c][e] && (age_q[c][e] != AGE_SAT)) begin
          age_d[c][e] = age_q[c][e] + 1'b1;
        end
      end
      pop[c]  = gnt[c] && (cnt_q[c] != '0);
      push[c] = req[c] && ((cnt_q[c] != CNT_FULL) || pop[c]);
      err_spur_d[c] = gnt[c] && (cnt_q[c] == '0);
      err_ovf_d[c]  = req[c] && (cnt_q[c] == CNT_FULL) && !gnt[c];
      // Ages compared here are pre-edge values, so they equal the latency of a grant on this edge.
      if (pop[c]) begin
        err_early_d[c]           = age_q[c][rd_q[c]] < AGE_MIN;
        valid_d[c][rd_q[c]]      = 1'b0;
        tmo_rep_d[c][rd_q[c]]    = 1'b0;
        rd_d[c]                  = ptr_inc(rd_q[c]);
      end else if (valid_q[c][rd_q[c]] && (age_q[c][rd_q[c]] == AGE_SAT) &&
                   !tmo_rep_q[c][rd_q[c]]) begin
        err_tmo_d[c]             = 1'b1;
        tmo_rep_d[c][rd_q[c]]    = 1'b1;
      end
      // On a full channel with a legal grant, wr_ptr equals rd_ptr: the freed slot is reused.
      if (push[c]) begin
        valid_d[c][wr_q[c]]      = 1'b1;
        age_d[c][wr_q[c]]        = AW'(1);
        tmo_rep_d[c][wr_q[c]]    = 1'b0;
        wr_d[c]                  = ptr_inc(wr_q[c]);
      end
      cnt_d[c] = cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
    end
    err_sticky_d = (err_sticky_q & ~{NCH{clr_err}}) |
                   err_spur_d | err_ovf_d | err_early_d | err_tmo_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        for (int e = 0; e < DEPTH; e++) begin
          valid_q[c][e]   <= 1'b0;
          age_q[c][e]     <= '0;
          tmo_rep_q[c][e] <= 1'b0;
        end
        rd_q[c]  <= '0;
        wr_q[c]  <= '0;
        cnt_q[c] <= '0;
      end
      err_spur_q   <= '0;
      err_ovf_q    <= '0;
      err_early_q  <= '0;
      err_tmo_q    <= '0;
      err_sticky_q <= '0;
    end else begin
      valid_q      <= valid_d;
      age_q        <= age_d;
      tmo_rep_q    <= tmo_rep_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      cnt_q        <= cnt_d;
      err_spur_q   <= err_spur_d;
      err_ovf_q    <= err_ovf_d;
      err_early_q  <= err_early_d;
      err_tmo_q    <= err_tmo_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign outstanding[g*CW +: CW] = cnt_q[g];
  end

  assign err_spur   = err_spur_q;
  assign err_ovf    = err_ovf_q;
  assign err_early  = err_early_q;
  assign err_tmo    = err_tmo_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_reqgnt_lat_monitor.sv
// tb/tb_reqgnt_lat_monitor.sv - directed self-checking bench for reqgnt_lat_monitor
module tb_reqgnt_lat_monitor;

  localparam int NCH = 4;
  localparam int CW  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    gnt;
  logic              clr_err;
  logic [NCH*CW-1:0] outstanding;
  logic [NCH-1:0]    err_spur, err_ovf, err_early, err_tmo, err_sticky;

  int tests = 0;
  int fails = 0;

  reqgnt_lat_monitor #(.NCH(4), .DEPTH(8), .MIN_LAT(2), .MAX_LAT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .clr_err(clr_err),
    .outstanding(outstanding), .err_spur(err_spur), .err_ovf(err_ovf),
    .err_early(err_early), .err_tmo(err_tmo), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] outs(input int ch);
    return outstanding[ch*CW +: CW];
  endfunction

  task automatic tick(input logic [NCH-1:0] r, input logic [NCH-1:0] g, input logic c);
    req = r; gnt = g; clr_err = c;
    @(posedge clk);
    #1;
    req = '0; gnt = '0; clr_err = 1'b0;
  endtask

  task automatic chk_err(input string tag, input logic [NCH-1:0] s, input logic [NCH-1:0] o,
                         input logic [NCH-1:0] e, input logic [NCH-1:0] t);
    chk({tag, "_spur"},  32'(err_spur),  32'(s));
    chk({tag, "_ovf"},   32'(err_ovf),   32'(o));
    chk({tag, "_early"}, 32'(err_early), 32'(e));
    chk({tag, "_tmo"},   32'(err_tmo),   32'(t));
  endtask

  initial begin
    rst = 1'b1; req = '0; gnt = '0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outstanding", 32'(outstanding), 32'h0);
    chk_err("rst", 4'h0, 4'h0, 4'h0, 4'h0);
    chk("rst_sticky", 32'(err_sticky), 32'h0);
    rst = 1'b0;

    // 1: ch0 req, grant after latency 4 -> clean
    tick(4'b0001, 4'b0000, 1'b0);
    chk("t1_cnt_up", 32'(outs(0)), 32'd1);
    repeat (3) tick(4'b0000, 4'b0000, 1'b0);
    tick(4'b0000, 4'b0001, 1'b0);
    chk("t1_cnt_down", 32'(outs(0)), 32'd0);
    chk_err("t1", 4'h0, 4'h0, 4'h0, 4'h0);
    chk("t1_sticky", 32'(err_sticky), 32'h0);

    // 2: spurious grant on ch1, sticky until clr, clr vs new error same edge
    tick(4'b0000, 4'b0010, 1'b0);
    chk_err("t2", 4'b0010, 4'h0, 4'h0, 4'h0);
    chk("t2_sticky", 32'(err_sticky), 32'h2);
    tick(4'b0000, 4'b0000, 1'b0);
    chk("t2_pulse_end", 32'(err_spur), 32'h0);
    chk("t2_sticky_hold", 32'(err_sticky), 32'h2);
    tick(4'b0000, 4'b0010, 1'b1);
    chk("t2_clr_vs_new", 32'(err_sticky), 32'h2);
    tick(4'b0000, 4'b0000, 1'b1);
    chk("t2_clr", 32'(err_sticky), 32'h0);

    // 4: ch3 latency 1 -> early
    tick(4'b1000, 4'b0000, 1'b0);
    chk("t4_cnt_up", 32'(outs(3)), 32'd1);
    tick(4'b0000, 4'b1000, 1'b0);
    chk_err("t4", 4'h0, 4'h0, 4'b1000, 4'h0);
    chk("t4_cnt", 32'(outs(3)), 32'd0);
    chk("t4_sticky", 32'(err_sticky), 32'h8);
    tick(4'b0000, 4'b0000, 1'b1);
    chk("t4_pulse_end", 32'(err_early), 32'h0);
    chk("t4_clr", 32'(err_sticky), 32'h0);

    // 3: ch2 nine reqs -> overflow, then timeouts in order
    repeat (8) tick(4'b0100, 4'b0000, 1'b0);
    chk("t3_full", 32'(outs(2)), 32'd8);
    chk("t3_no_ovf_yet", 32'(err_ovf), 32'h0);
    tick(4'b0100, 4'b0000, 1'b0);
    chk_err("t3_ovf", 4'h0, 4'b0100, 4'h0, 4'h0);
    chk("t3_full_hold", 32'(outs(2)), 32'd8);
    tick(4'b0000, 4'b0000, 1'b0);
    chk_err("t3_tmo1", 4'h0, 4'h0, 4'h0, 4'b0100);
    tick(4'b0000, 4'b0000, 1'b0);
    chk("t3_tmo_once", 32'(err_tmo), 32'h0);
    tick(4'b0000, 4'b0100, 1'b0);
    chk_err("t3_late_pop", 4'h0, 4'h0, 4'h0, 4'h0);
    chk("t3_cnt7", 32'(outs(2)), 32'd7);
    tick(4'b0000, 4'b0000, 1'b0);
    chk("t3_tmo2", 32'(err_tmo), 32'h4);
    repeat (7) tick(4'b0000, 4'b0100, 1'b0);
    chk("t3_drained", 32'(outs(2)), 32'd0);
    chk_err("t3_drain", 4'h0, 4'h0, 4'h0, 4'h0);
    tick(4'b0000, 4'b0000, 1'b1);
    chk("t3_clr", 32'(err_sticky), 32'h0);

    // 5: ch0 full with simultaneous req and gnt
    repeat (8) tick(4'b0001, 4'b0000, 1'b0);
    chk("t5_full", 32'(outs(0)), 32'd8);
    tick(4'b0001, 4'b0001, 1'b0);
    chk("t5_cnt_stays", 32'(outs(0)), 32'd8);
    chk_err("t5", 4'h0, 4'h0, 4'h0, 4'h0);
    repeat (8) tick(4'b0000, 4'b0001, 1'b0);
    chk("t5_drained", 32'(outs(0)), 32'd0);
    chk_err("t5_drain", 4'h0, 4'h0, 4'h0, 4'h0);
    tick(4'b0000, 4'b0001, 1'b0);
    chk("t5_extra_gnt_spur", 32'(err_spur), 32'h1);
    tick(4'b0000, 4'b0000, 1'b1);

    // 6: async reset with 3 outstanding on ch1 and a live pulse on ch0
    repeat (2) tick(4'b0010, 4'b0000, 1'b0);
    tick(4'b0010, 4'b0001, 1'b0);
    chk("t6_cnt3", 32'(outs(1)), 32'd3);
    chk("t6_pulse_live", 32'(err_spur), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_outstanding", 32'(outstanding), 32'h0);
    chk_err("t6_async", 4'h0, 4'h0, 4'h0, 4'h0);
    chk("t6_async_sticky", 32'(err_sticky), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(4'b0000, 4'b0010, 1'b0);
    chk_err("t6_post", 4'b0010, 4'h0, 4'h0, 4'h0);
    chk("t6_post_cnt", 32'(outs(1)), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
